// File: rtl/line_xfer_responder.sv
// line_xfer_responder
// Moves one 32-halfword cache line between the cache port and a simple
// req/ack memory port. A fill reads the line from memory and strobes each
// halfword into the cache. A write-back reads the line out of the cache
// through a small FIFO and writes it to memory.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   ddr_rd, ddr_wr           level requests: line fill / line write-back
//   hiaddr                   line address, latched when a burst starts
//   ddr_dout                 cache read data, valid RD_LAT cycles after cache_read_data
//   ddr_din                  halfword to the cache, captured on cache_write_data
//   cache_write_data         one-cycle strobe: cache captures ddr_din
//   cache_read_data          one-cycle strobe: cache advances its read pointer
//   mem_req, mem_we          memory request and write enable
//   mem_addr, mem_wdata      halfword address and write data
//   mem_ack, mem_rdata       memory acknowledge and read data
//   busy                     a burst is in progress
//   err                      sticky memory timeout flag
//
// Build option: define LXR_TIMEOUT_EN to abandon memory after 256 cycles
// without an ack. The cache side still sees all 32 strobes and err is set.
// Without it the block waits for mem_ack indefinitely and err is 0.
//
// state | meaning
// IDLE  | waiting for ddr_wr (priority) or ddr_rd
// WB    | write-back: cache -> FIFO -> memory
// FILL  | line fill: memory -> cache
// GAP   | one dead cycle between bursts, requests ignored
module line_xfer_responder #(
    parameter int ADDR       = 25,
    parameter int LINE       = 6,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ddr_rd,
    input  logic                 ddr_wr,
    input  logic [ADDR-LINE-1:0] hiaddr,
    input  logic [15:0]          ddr_dout,
    output logic [15:0]          ddr_din,
    output logic                 cache_write_data,
    output logic                 cache_read_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR-2:0]      mem_addr,
    output logic [15:0]          mem_wdata,
    input  logic                 mem_ack,
    input  logic [15:0]          mem_rdata,
    output logic                 busy,
    output logic                 err
);
    localparam int IDX_W = LINE - 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W:0] N_WORDS  = (IDX_W+1)'(1 << IDX_W);
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'((1 << IDX_W) - 1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WB, FILL, GAP} state_t;
    state_t state_q, state_d;

    logic [ADDR-LINE-1:0] line_q;
    logic [IDX_W:0]       done_q, done_d;   // words finished (acked or discarded)
    logic [IDX_W:0]       reads_q;          // cache reads issued
    logic [CW-1:0]        outst_q;          // FIFO entries + reads still in flight
    logic [RD_LAT-1:0]    pipe_q;           // strobe history, tap RD_LAT-1 = data valid
    logic [15:0]          fifo_q [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q, rptr_q, rptr_d;
    logic [CW-1:0]        cnt_q, cnt_pop, cnt_d;
    logic [15:0]          head_d;
    logic                 to_q, to_d;       // memory abandoned for this burst
    logic                 tmo_hit;
    logic                 ack_ok, push, pop, adv, last, issue, req_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (ddr_wr) state_d = WB;
                      else if (ddr_rd) state_d = FILL;
            WB, FILL: if (last) state_d = GAP;
            GAP:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_ok  = mem_req & mem_ack;
        push    = (state_q == WB) & pipe_q[RD_LAT-1];
        pop     = (state_q == WB) & (cnt_q != '0) & (ack_ok | to_q);
        // After a timeout a fill keeps strobing one zero word per cycle.
        adv     = (state_q == FILL) ? (ack_ok | to_q) : pop;
        last    = adv & (done_q == LAST_IDX);
        issue   = (state_q == WB) & (reads_q != N_WORDS) & (outst_q != DEPTH_C);
        cnt_pop = cnt_q - CW'(pop);
        cnt_d   = cnt_pop + CW'(push);
        rptr_d  = rptr_q + PW'(pop);
        // An empty FIFO being pushed this cycle exposes the incoming word as head.
        head_d  = (cnt_pop == '0) ? ddr_dout : fifo_q[rptr_d];
        done_d  = done_q + (IDX_W+1)'(adv);
        to_d    = to_q | tmo_hit;
        // Request only from the cycle after entering a burst state.
        req_d   = !to_d && (state_d == state_q) &&
                  ((state_q == FILL) || ((state_q == WB) && (cnt_d != '0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q           <= '0;
            done_q           <= '0;
            reads_q          <= '0;
            outst_q          <= '0;
            cnt_q            <= '0;
            wptr_q           <= '0;
            rptr_q           <= '0;
            to_q             <= 1'b0;
            pipe_q           <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            ddr_din          <= '0;
            cache_write_data <= 1'b0;
            cache_read_data  <= 1'b0;
        end else begin
            mem_req          <= req_d;
            mem_we           <= req_d & (state_q == WB);
            cache_read_data  <= issue;
            cache_write_data <= (state_q == FILL) & adv;
            if ((state_q == FILL) && adv) ddr_din <= to_q ? 16'h0000 : mem_rdata;
            pipe_q[0] <= cache_read_data;
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            if (state_q == IDLE) begin
                if (ddr_wr || ddr_rd) line_q <= hiaddr;
                done_q  <= '0;
                reads_q <= '0;
                outst_q <= '0;
                cnt_q   <= '0;
                wptr_q  <= '0;
                rptr_q  <= '0;
                to_q    <= 1'b0;
            end else begin
                done_q    <= done_d;
                reads_q   <= reads_q + (IDX_W+1)'(issue);
                outst_q   <= outst_q + CW'(issue) - CW'(pop);
                cnt_q     <= cnt_d;
                wptr_q    <= wptr_q + PW'(push);
                rptr_q    <= rptr_d;
                to_q      <= to_d;
                mem_addr  <= {line_q, done_d[IDX_W-1:0]};
                mem_wdata <= (state_q == WB) ? head_d : 16'h0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= ddr_dout;
    end

`ifdef LXR_TIMEOUT_EN
    logic [7:0] tmo_q;
    logic       err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (!mem_req || mem_ack) tmo_q <= '0;
            else                     tmo_q <= tmo_q + 8'd1;
            if (tmo_hit) err_q <= 1'b1;
        end
    end

    assign tmo_hit = mem_req & ~mem_ack & (tmo_q == 8'hFF);
    assign err     = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_line_xfer_responder.sv
module tb_line_xfer_responder;
    localparam int RD_LAT = 2;

    logic        clk, rst_n, ddr_rd, ddr_wr;
    logic [18:0] hiaddr;
    logic [15:0] ddr_dout, ddr_din, mem_wdata, mem_rdata;
    logic        cache_write_data, cache_read_data;
    logic        mem_req, mem_we, mem_ack, busy, err;
    logic [23:0] mem_addr;

    int vec = 0;
    int miscmp = 0;
    int cyc = 0;
    logic [15:0] rd_seq;
    logic [15:0] pend_data[$];
    int          pend_due[$];

    line_xfer_responder #(.ADDR(25), .LINE(6), .RD_LAT(RD_LAT), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .hiaddr(hiaddr),
        .ddr_dout(ddr_dout), .ddr_din(ddr_din), .cache_write_data(cache_write_data),
        .cache_read_data(cache_read_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    // Memory model: read data is a fixed function of the address.
    assign mem_rdata = mem_addr[15:0] ^ 16'hC3C3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one cycle; sample at the falling edge and run the cache read model.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (cache_read_data === 1'b1) begin
            pend_data.push_back(rd_seq);
            pend_due.push_back(cyc + RD_LAT);
            rd_seq++;
        end
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            ddr_dout = pend_data.pop_front();
            void'(pend_due.pop_front());
        end
    endtask

    task automatic cache_clear();
        rd_seq = 16'h0000;
        pend_data.delete();
        pend_due.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ddr_rd = 1'b0; ddr_wr = 1'b0; hiaddr = '0;
        ddr_dout = '0; mem_ack = 1'b0;
        cache_clear();
        repeat (3) step();
        vec++;
        if ({mem_req, mem_we, cache_write_data, cache_read_data, busy, err} !== 6'b0) begin
            miscmp++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_req, mem_we, cache_write_data, cache_read_data, busy, err});
        end
        vec++;
        if ({mem_addr, mem_wdata, ddr_din} !== 56'h0) begin
            miscmp++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, ddr_din});
        end
        rst_n = 1'b1;
        step();
        vec++;
        if (busy !== 1'b0) begin
            miscmp++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_fill_burst();
        logic [23:0] base = 24'h2468A0;
        logic [23:0] a;
        logic [15:0] exp_din [$];
        logic [15:0] e;
        int nack = 0, nstb = 0, busy_cyc = 0;
        bit exp_cwd = 0, done = 0;
        hiaddr = 19'h12345; mem_ack = 1'b1; ddr_rd = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            step();
            ddr_rd = 1'b0;
            if (busy) busy_cyc++;
            if (cache_write_data || exp_cwd) begin
                vec++;
                if (cache_write_data !== exp_cwd) begin
                    miscmp++;
                    $display("FAIL fill_strobe_timing: got %b expected %b", cache_write_data, exp_cwd);
                end else begin
                    e = exp_din.pop_front();
                    vec++;
                    if (ddr_din !== e) begin
                        miscmp++;
                        $display("FAIL fill_data[%0d]: got %h expected %h", nstb, ddr_din, e);
                    end
                    nstb++;
                end
            end
            exp_cwd = 0;
            if (mem_req && mem_ack) begin
                a = base + 24'(nack);
                vec++;
                if (mem_addr !== a || mem_we !== 1'b0) begin
                    miscmp++;
                    $display("FAIL fill_addr[%0d]: got %h/we%b expected %h/we0", nack, mem_addr, mem_we, a);
                end
                exp_din.push_back(a[15:0] ^ 16'hC3C3);
                nack++;
                exp_cwd = 1;
            end
            if (busy_cyc > 0 && !busy && !exp_cwd) done = 1;
        end
        vec++;
        if (!done || nack != 32 || nstb != 32 || busy_cyc != 34) begin
            miscmp++;
            $display("FAIL fill_totals: got done=%0d acks=%0d strobes=%0d busy=%0d expected 1/32/32/34",
                     done, nack, nstb, busy_cyc);
        end
    endtask

    task automatic test_writeback();
        logic [23:0] base = 24'h015780;
        int nack = 0, nrd = 0, worst = 0;
        bit seen = 0, done = 0;
        cache_clear();
        hiaddr = 19'h00ABC; mem_ack = 1'b0; ddr_wr = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            ddr_wr = 1'b0;
            mem_ack = (cyc % 3 == 0);
            if (busy) seen = 1;
            if (cache_read_data) begin
                nrd++;
                if (nrd - nack > worst) worst = nrd - nack;
            end
            if (mem_req && mem_ack) begin
                vec++;
                if (mem_addr !== base + 24'(nack) || mem_we !== 1'b1 || mem_wdata !== 16'(nack)) begin
                    miscmp++;
                    $display("FAIL wb_write[%0d]: got %h/%h/we%b expected %h/%h/we1",
                             nack, mem_addr, mem_wdata, mem_we, base + 24'(nack), 16'(nack));
                end
                nack++;
            end
            if (seen && !busy) done = 1;
        end
        vec++;
        if (worst > 4) begin
            miscmp++;
            $display("FAIL wb_outstanding: got %0d expected at most 4", worst);
        end
        vec++;
        if (!done || nack != 32 || nrd != 32) begin
            miscmp++;
            $display("FAIL wb_totals: got done=%0d writes=%0d reads=%0d expected 1/32/32", done, nack, nrd);
        end
    endtask

    task automatic test_wb_then_fill();
        logic [23:0] old_base = 24'h1579A0;
        int nack = 0, last_wb = 0, first_fill = 0;
        bit done = 0;
        cache_clear();
        hiaddr = 19'h0ABCD; mem_ack = 1'b1; ddr_wr = 1'b1; ddr_rd = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            ddr_wr = 1'b0;
            if (mem_req && mem_ack) begin
                vec++;
                if (nack < 32) begin
                    if (mem_we !== 1'b1 || mem_addr !== old_base + 24'(nack) || mem_wdata !== 16'(nack)) begin
                        miscmp++;
                        $display("FAIL mix_wb[%0d]: got %h/%h/we%b expected %h/%h/we1",
                                 nack, mem_addr, mem_wdata, mem_we, old_base + 24'(nack), 16'(nack));
                    end
                    last_wb = cyc;
                    if (nack == 15) hiaddr = 19'h00010;
                end else begin
                    if (mem_we !== 1'b0 || mem_addr !== 24'h000200 + 24'(nack - 32)) begin
                        miscmp++;
                        $display("FAIL mix_fill[%0d]: got %h/we%b expected %h/we0",
                                 nack - 32, mem_addr, mem_we, 24'h000200 + 24'(nack - 32));
                    end
                    if (nack == 32) begin
                        first_fill = cyc;
                        ddr_rd = 1'b0;
                    end
                end
                nack++;
            end
            if (nack == 64 && !busy) done = 1;
        end
        vec++;
        if (!done || nack != 64 || first_fill - last_wb != 4) begin
            miscmp++;
            $display("FAIL mix_totals: got done=%0d acks=%0d spacing=%0d expected 1/64/4",
                     done, nack, first_fill - last_wb);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [23:0] base = 24'h00EEE0;
        int nack = 0;
        bit first = 1, done = 0;
        hiaddr = 19'h00777; mem_ack = 1'b1; ddr_rd = 1'b1;
        for (int i = 0; i < 40 && nack < 10; i++) begin
            step();
            if (mem_req && mem_ack) nack++;
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({mem_req, mem_we, cache_write_data, cache_read_data, busy} !== 5'b0 ||
            {mem_addr, mem_wdata, ddr_din} !== 56'h0) begin
            miscmp++;
            $display("FAIL rst_async: got ctrl=%b data=%h expected all 0",
                     {mem_req, mem_we, cache_write_data, cache_read_data, busy},
                     {mem_addr, mem_wdata, ddr_din});
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        vec++;
        if ({mem_req, cache_write_data, cache_read_data} !== 3'b000 || busy !== 1'b1) begin
            miscmp++;
            $display("FAIL rst_release: got req/cwd/crd=%b busy=%b expected 000 busy=1",
                     {mem_req, cache_write_data, cache_read_data}, busy);
        end
        ddr_rd = 1'b0;
        nack = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            if (mem_req && mem_ack) begin
                if (first) begin
                    vec++;
                    if (mem_addr !== base) begin
                        miscmp++;
                        $display("FAIL rst_restart_addr: got %h expected %h", mem_addr, base);
                    end
                    first = 0;
                end
                nack++;
            end
            if (!busy) done = 1;
            else step();
        end
        vec++;
        if (!done || nack != 32) begin
            miscmp++;
            $display("FAIL rst_restart_total: got done=%0d acks=%0d expected 1/32", done, nack);
        end
    endtask

`ifdef LXR_TIMEOUT_EN
    task automatic test_timeout();
        int req_cyc = 0, nstb = 0, bad = 0;
        bit seen = 0, done = 0;
        hiaddr = 19'h00100; mem_ack = 1'b0; ddr_rd = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            ddr_rd = 1'b0;
            if (busy) seen = 1;
            if (mem_req) req_cyc++;
            if (cache_write_data) begin
                nstb++;
                if (ddr_din !== 16'h0000) bad++;
            end
            if (seen && !busy) done = 1;
        end
        vec++;
        if (!done || req_cyc != 256 || nstb != 32 || bad != 0) begin
            miscmp++;
            $display("FAIL tmo_burst: got done=%0d req=%0d strobes=%0d nonzero=%0d expected 1/256/32/0",
                     done, req_cyc, nstb, bad);
        end
        repeat (5) step();
        vec++;
        if (err !== 1'b1) begin
            miscmp++;
            $display("FAIL tmo_err_sticky: got %b expected 1", err);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vec++;
        if (err !== 1'b0) begin
            miscmp++;
            $display("FAIL tmo_err_clear: got %b expected 0", err);
        end
    endtask
`else
    task automatic test_stall();
        int nack = 0, bad = 0;
        logic [23:0] last_a = '0;
        bit done = 0;
        hiaddr = 19'h7FFFF; mem_ack = 1'b0; ddr_rd = 1'b1;
        for (int i = 0; i < 5 && !mem_req; i++) begin
            step();
            ddr_rd = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            if (mem_req !== 1'b1 || mem_addr !== 24'hFFFFE0) bad++;
            step();
        end
        vec++;
        if (bad != 0) begin
            miscmp++;
            $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
        end
        vec++;
        if (err !== 1'b0) begin
            miscmp++;
            $display("FAIL stall_err: got %b expected 0", err);
        end
        mem_ack = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            if (mem_req && mem_ack) begin
                nack++;
                last_a = mem_addr;
            end
            if (!busy) done = 1;
            else step();
        end
        vec++;
        if (!done || nack != 32 || last_a !== 24'hFFFFFF) begin
            miscmp++;
            $display("FAIL stall_finish: got done=%0d acks=%0d last=%h expected 1/32/ffffff",
                     done, nack, last_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_burst();
        test_writeback();
        test_wb_then_fill();
        test_reset_mid_fill();
`ifdef LXR_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule

// File: doc/line_xfer_responder.md
LINE_XFER_RESPONDER -- requirements
Module: line_xfer_responder

Interface
REQ-001 SHALL have parameter ADDR, default 25, meaning byte address width.
REQ-002 SHALL have parameter LINE, default 6, meaning log2 bytes per line (32 halfwords).
REQ-003 SHALL have parameter RD_LAT, default 2, meaning cycles from cache_read_data strobe to valid ddr_dout.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning write-back halfword buffer entries (power of 2).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ddr_rd, input, 1, level line-fill request.
REQ-008 SHALL have port ddr_wr, input, 1, level line write-back request.
REQ-009 SHALL have port hiaddr, input, ADDR-LINE, line address.
REQ-010 SHALL have port ddr_dout, input, 16, halfword from cache, valid RD_LAT cycles after each cache_read_data strobe.
REQ-011 SHALL have port ddr_din, output, 16, halfword to cache.
REQ-012 SHALL have port cache_write_data, output, 1, one-cycle strobe: cache captures ddr_din.
REQ-013 SHALL have port cache_read_data, output, 1, one-cycle strobe: cache advances read pointer.
REQ-014 SHALL have ports mem_req (out 1), mem_we (out 1), mem_addr (out ADDR-1, halfword address), mem_wdata (out 16), mem_ack (in 1), mem_rdata (in 16, valid with mem_ack).
REQ-015 SHALL have ports busy (out 1, state != IDLE) and err (out 1, sticky timeout flag).

Function
REQ-016 SHALL implement states IDLE, WB, FILL, GAP.
REQ-017 In IDLE, ddr_wr=1 SHALL latch hiaddr and enter WB; else ddr_rd=1 SHALL latch hiaddr and enter FILL; ddr_wr has priority when both are high.
REQ-018 mem_addr SHALL equal {latched hiaddr, 5-bit word index}, index 0..31 ascending, no wrap within a burst.
REQ-019 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable while mem_req=1 and mem_ack=0; after an ack the next word SHALL be presented the following cycle, with mem_req allowed to stay high.
REQ-020 FILL: every mem_ack SHALL produce cache_write_data=1 with ddr_din=mem_rdata exactly one cycle later; the 32nd ack SHALL enter GAP.
REQ-021 WB: cache_read_data SHALL be issued only when the count of FIFO entries plus in-flight reads is below FIFO_DEPTH and fewer than 32 reads have been issued.
REQ-022 WB: ddr_dout SHALL be pushed into the FIFO RD_LAT cycles after each strobe; mem_req/mem_we=1 SHALL be asserted while the FIFO is non-empty, with mem_wdata = head; mem_ack SHALL pop the FIFO; the 32nd ack SHALL enter GAP.
REQ-023 Simultaneous FIFO push and pop SHALL keep the occupancy unchanged; the FIFO SHALL never overflow or underflow.
REQ-024 GAP SHALL last one cycle, ignore requests, then return to IDLE, so that a ddr_rd still high after write-back starts a fill using the hiaddr value current at that point.
REQ-025 Requests deasserting mid-burst SHALL NOT abort the burst; exactly 32 cache strobes SHALL occur per burst.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE and clear FIFO, counters and err; mem_req, mem_we, cache_write_data, cache_read_data and busy go to 0; mem_addr, mem_wdata and ddr_din go to 0.
REQ-027 Reset mid-burst SHALL abandon the burst; no strobe or mem_req SHALL appear in the cycle after rst_n rises unless a request is pending.

Configuration
REQ-028 Macro LXR_TIMEOUT_EN SHALL select memory timeout: when defined, an 8-bit counter clears on mem_ack or mem_req=0 and increments while mem_req=1.
REQ-029 With LXR_TIMEOUT_EN defined, 256 cycles without ack SHALL drop mem_req, set err, and still complete the 32 cache strobes (FILL: ddr_din=0; WB: data discarded) before GAP.
REQ-030 Without LXR_TIMEOUT_EN, the block SHALL wait indefinitely for mem_ack and err SHALL be tied to 0.

Verification
REQ-031 ddr_rd=1, hiaddr=0x12345, mem_ack every cycle -> mem_addr 0x2468A0..0x2468BF; 32 cache_write_data strobes, each 1 cycle after its ack, with matching data; busy for 34 cycles.
REQ-032 ddr_wr=1, RD_LAT=2, memory acks every 3rd cycle -> never more than 4 outstanding; 32 writes in order with data = cache sequence 0x0000..0x001F.
REQ-033 ddr_wr and ddr_rd both high, hiaddr changing to 0x00010 at word 16 -> WB completes to the old line; GAP; fill from 0x000200.
REQ-034 rst_n low at FILL word 10 -> all outputs 0 asynchronously; ddr_rd=1 after release -> fill restarts at index 0.
REQ-035 LXR_TIMEOUT_EN defined, mem_ack stuck 0 in FILL -> mem_req drops after 256 cycles, err=1, 32 strobes with ddr_din=0, IDLE; err holds until reset.
